spi_word_router: RTL

- Generalised successor to the fixed two-output address split at the chip top.
- Takes the word-addressed write stream from spi_in and splits it across NUM_CH contiguous address windows. Each window has a parametrised size.
- Each write is rebased to a channel-local address and a one-hot write strobe is issued to the matching LED output driver (ws2812_out, icnd2110_out, ...).
- Adds frame tracking from the SPI chip-select, a per-frame completion flag, and a saturating count of out-of-range writes.

---
 rtl/spi_router_pkg.sv | 44 ++++
 rtl/cs_edge_sync.sv | 31 +++
 rtl/spi_word_router.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/spi_router_pkg.sv
// rtl/spi_router_pkg.sv - frame states, window helpers and board defaults for spi_word_router
package spi_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_CLOSE  = 2'd2
  } frame_state_t;

  // Widest packed CH_WORDS vector the helpers accept (8 channels x 32 bits)
  localparam int MAX_WORDS_W = 256;

  // supersweet board: channel 0 = 1305 words, channel 1 = 336 words
  localparam logic [25:0] SUPERSWEET_CH_WORDS = {13'd336, 13'd1305};

  // Word count of channel idx from the packed count vector
  function automatic int unsigned ch_len(input logic [MAX_WORDS_W-1:0] words,
                                         input int aw, input int idx);
    logic [MAX_WORDS_W-1:0] field;
    field = (words >> (idx * aw)) & ((MAX_WORDS_W'(1) << aw) - MAX_WORDS_W'(1));
    return 32'(field);
  endfunction

  // First global address of channel idx; idx == num gives the total span
  function automatic int unsigned ch_base(input logic [MAX_WORDS_W-1:0] words,
                                          input int aw, input int idx);
    int unsigned sum;
    sum = 0;
    for (int j = 0; j < idx; j++) sum = sum + ch_len(words, aw, j);
    return sum;
  endfunction

  // Channels with a non-zero window
  function automatic logic [7:0] enabled_mask(input logic [MAX_WORDS_W-1:0] words,
                                              input int aw, input int num);
    logic [7:0] m;
    m = '0;
    for (int j = 0; j < 8; j++) begin
      if (j < num) m[j] = (ch_len(words, aw, j) != 0);
    end
    return m;
  endfunction

endpackage

// File: rtl/cs_edge_sync.sv
// rtl/cs_edge_sync.sv - 2-FF synchroniser with rise/fall pulse detector for an async pin
module cs_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resynchronise the pin and remember the previous synchronised level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  // One-cycle pulses, valid in the cycle the synchronised level changes
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_word_router.sv
// rtl/spi_word_router.sv - splits the SPI word stream into per-channel windows; option SPI_WORD_ROUTER_STATS_EN
module spi_word_router
  import spi_router_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 13,
  parameter logic [NUM_CH*ADDR_W-1:0] CH_WORDS = SUPERSWEET_CH_WORDS,
  parameter int OVF_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic                in_strobe,
  input  logic                spi_cs_n,
  output logic [DATA_W-1:0]   out_data,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [NUM_CH-1:0]   out_strobe,
  output logic                frame_end,
  output logic                frame_complete,
  output logic [OVF_W-1:0]    overflow_count
`ifdef SPI_WORD_ROUTER_STATS_EN
  ,
  output logic [NUM_CH*ADDR_W-1:0] ch_word_count
`endif
);

  localparam logic [MAX_WORDS_W-1:0] WORDS_EXT = MAX_WORDS_W'(CH_WORDS);
  localparam int unsigned TOTAL_WORDS = ch_base(WORDS_EXT, ADDR_W, NUM_CH);
  localparam logic [NUM_CH-1:0] EN_MASK = NUM_CH'(enabled_mask(WORDS_EXT, ADDR_W, NUM_CH));
  localparam logic [ADDR_W:0] ONE = (ADDR_W+1)'(1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("spi_word_router: NUM_CH must be 1..8");
  end
  if (TOTAL_WORDS > (2 ** ADDR_W) - 1) begin : g_bad_words
    $error("spi_word_router: sum of CH_WORDS exceeds the address space");
  end

  logic [ADDR_W:0]     w_base [NUM_CH];
  logic [ADDR_W:0]     w_len  [NUM_CH];
  logic [ADDR_W:0]     w_addr_ext;
  logic [NUM_CH-1:0]   w_hit;
  logic [NUM_CH-1:0]   w_last;
  logic [NUM_CH-1:0]   w_done_now;
  logic [ADDR_W-1:0]   w_local;
  logic                w_cs_rise;
  logic                w_cs_fall;
  logic                w_frame_start;

  logic [DATA_W-1:0]   r_out_data;
  logic [ADDR_W-1:0]   r_out_addr;
  logic [NUM_CH-1:0]   r_out_strobe;
  logic [OVF_W-1:0]    r_ovf;
  frame_state_t        r_state;
  logic                r_frame_end;
  logic                r_frame_complete;
  logic [NUM_CH-1:0]   r_done_mask;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_win
    assign w_base[g] = (ADDR_W+1)'(ch_base(WORDS_EXT, ADDR_W, g));
    assign w_len[g]  = (ADDR_W+1)'(ch_len(WORDS_EXT, ADDR_W, g));
  end

  assign w_addr_ext = {1'b0, in_addr};

  // Window lookup: at most one channel can match since windows are disjoint
  always_comb begin
    w_hit   = '0;
    w_last  = '0;
    w_local = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if ((w_len[i] != '0) && (w_addr_ext >= w_base[i]) &&
          (w_addr_ext < w_base[i] + w_len[i])) begin
        w_hit[i]  = 1'b1;
        w_local   = ADDR_W'(w_addr_ext - w_base[i]);
        w_last[i] = ((w_addr_ext - w_base[i]) == (w_len[i] - ONE));
      end
    end
  end

  assign w_done_now = in_strobe ? w_last : '0;

  cs_edge_sync u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (spi_cs_n),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  assign w_frame_start = (r_state == ST_IDLE) && w_cs_fall;

  // Routing stage: strobe, rebased address and data; misses bump the saturating counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_strobe <= '0;
      r_out_addr   <= '0;
      r_out_data   <= '0;
      r_ovf        <= '0;
    end else begin
      r_out_strobe <= in_strobe ? w_hit : '0;
      if (in_strobe && (w_hit != '0)) begin
        r_out_addr <= w_local;
        r_out_data <= in_data;
      end
      if (in_strobe && (w_hit == '0) && (r_ovf != '1)) r_ovf <= r_ovf + OVF_W'(1);
    end
  end

  // Frame FSM: last-word tracking per channel, completion verdict on cs rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_frame_end      <= 1'b0;
      r_frame_complete <= 1'b0;
      r_done_mask      <= '0;
    end else begin
      r_frame_end <= 1'b0;
      r_done_mask <= r_done_mask | w_done_now;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_state          <= ST_ACTIVE;
            r_done_mask      <= '0;
            r_frame_complete <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state          <= ST_CLOSE;
            r_frame_end      <= 1'b1;
            r_frame_complete <= (((r_done_mask | w_done_now) & EN_MASK) == EN_MASK);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_WORD_ROUTER_STATS_EN
  logic [ADDR_W-1:0] r_word_cnt [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stats
    // Per-channel routed-word count, restarted at each frame start
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_word_cnt[g] <= '0;
      end else if (w_frame_start) begin
        r_word_cnt[g] <= '0;
      end else if (r_out_strobe[g] && (r_word_cnt[g] != '1)) begin
        r_word_cnt[g] <= r_word_cnt[g] + ADDR_W'(1);
      end
    end
    assign ch_word_count[g*ADDR_W +: ADDR_W] = r_word_cnt[g];
  end
`endif

  assign out_data       = r_out_data;
  assign out_addr       = r_out_addr;
  assign out_strobe     = r_out_strobe;
  assign frame_end      = r_frame_end;
  assign frame_complete = r_frame_complete;
  assign overflow_count = r_ovf;

endmodule
